// File: rtl/inst_fetch.sv
// Instruction fetch stage for the NPU core decoder.
// Reads 128-bit instructions from the instruction RAM starting at a
// programmed PC and prefetches them into a small FIFO. The FIFO head goes to
// the decoder over a valid/ready handshake. JUMP is resolved locally, STOP
// ends the run, and a decoder error flag halts the stage until restarted.
//
// Optional build macro: INST_FETCH_PERF_CNT_EN adds the saturating
// o_inst_cnt / o_stall_cnt performance counters.
//
// Handshake: the decoder takes o_inst in any cycle where o_inst_valid and
// i_inst_ready are both high. o_inst and o_pc stay stable while
// o_inst_valid is high and i_inst_ready is low. i_err_inst is only
// meaningful in a cycle where o_inst_valid is high.
module inst_fetch #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 2,
  parameter int IMEM_LAT   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_pc,
  output logic              o_imem_rd_en,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [127:0]      i_imem_rdata,
  output logic [127:0]      o_inst,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_err_inst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_pc,
  output logic [1:0]        o_state
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       o_inst_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + IMEM_LAT + 1) + 1;

  localparam logic [4:0] OP_JUMP = 5'b11100;
  localparam logic [4:0] OP_STOP = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;

  // Prefetch FIFO storage and pointers
  logic [127:0]        fifo_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    fifo_cnt;

  // In-flight read tracking, stage IMEM_LAT-1 lines up with returning data
  logic [IMEM_LAT-1:0] inf_v;
  logic [ADDR_W-1:0]   inf_a [IMEM_LAT];

  logic                fifo_empty;
  logic [127:0]        head_inst;
  logic [4:0]          head_op;
  logic                in_fetch;
  logic                head_jump;
  logic                pop;
  logic                push;
  logic                err_hit;
  logic                stop_hs;
  logic                flush;
  logic                start_ok;
  logic [OCC_W-1:0]    occ;
  logic [ADDR_W-1:0]   jump_target;

  // Head decode, handshake qualification and read-issue credit
  always_comb begin
    fifo_empty   = (fifo_cnt == '0);
    head_inst    = fifo_inst[rd_ptr];
    head_op      = head_inst[127:123];
    jump_target  = ADDR_W'(head_inst[122:111]);
    in_fetch     = (state == S_FETCH);
    head_jump    = in_fetch & ~fifo_empty & (head_op == OP_JUMP);
    o_inst_valid = in_fetch & ~fifo_empty & (head_op != OP_JUMP);
    o_inst       = fifo_empty ? '0 : head_inst;
    o_pc         = fifo_empty ? '0 : fifo_pc[rd_ptr];
    pop          = o_inst_valid & i_inst_ready & ~i_err_inst;
    err_hit      = o_inst_valid & i_err_inst;
    stop_hs      = pop & (head_op == OP_STOP);
    flush        = head_jump | err_hit | stop_hs;
    push         = inf_v[IMEM_LAT-1];
    start_ok     = i_start & ((state == S_IDLE) | (state == S_ERR));
    // A pop this cycle frees a slot before the issued read can land
    occ = OCC_W'(fifo_cnt);
    for (int i = 0; i < IMEM_LAT; i++) begin
      occ = occ + OCC_W'(inf_v[i]);
    end
    if (pop) begin
      occ = occ - OCC_W'(1);
    end
    o_imem_rd_en = in_fetch & ~flush & (occ < OCC_W'(FIFO_DEPTH));
    o_imem_addr  = fetch_pc;
    o_busy       = in_fetch;
    o_state      = state;
  end

  // Control FSM: run state, fetch PC, done pulse and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (i_start) begin
            state    <= S_FETCH;
            fetch_pc <= i_start_pc;
            o_err    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (err_hit) begin
            state <= S_ERR;
            o_err <= 1'b1;
          end else if (stop_hs) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else if (head_jump) begin
            fetch_pc <= jump_target;
          end else if (o_imem_rd_en) begin
            fetch_pc <= fetch_pc + ADDR_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // In-flight shift register, emptied on any redirect or termination
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      inf_v <= '0;
      for (int i = 0; i < IMEM_LAT; i++) begin
        inf_a[i] <= '0;
      end
    end else begin
      inf_v[0] <= o_imem_rd_en;
      inf_a[0] <= fetch_pc;
      for (int i = 1; i < IMEM_LAT; i++) begin
        inf_v[i] <= inf_v[i-1];
        inf_a[i] <= inf_a[i-1];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage: returning data is written with the address it was read from
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= i_imem_rdata;
      fifo_pc[wr_ptr]   <= inf_a[IMEM_LAT-1];
    end
  end

`ifdef INST_FETCH_PERF_CNT_EN
  // Saturating counters of accepted instructions and decoder stall cycles
  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      o_inst_cnt  <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (pop && (o_inst_cnt != 32'hFFFF_FFFF)) begin
        o_inst_cnt <= o_inst_cnt + 32'd1;
      end
      if (o_inst_valid && !i_inst_ready && (o_stall_cnt != 32'hFFFF_FFFF)) begin
        o_stall_cnt <= o_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: linear run, backpressure, jump,
// PC wrap, decoder error and reset in the middle of a run.
module tb_inst_fetch;

  localparam int ADDR_W = 12;
  localparam logic [4:0] OP_JUMP  = 5'b11100;
  localparam logic [4:0] OP_STOP  = 5'b11111;
  localparam logic [4:0] OP_DMA   = 5'b00010;
  localparam logic [4:0] OP_IOB2N = 5'b00101;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [127:0]      imem_rdata;
  logic [127:0]      inst;
  logic              inst_valid;
  logic              inst_ready;
  logic              err_inst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0]       inst_cnt;
  logic [31:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0]      mem [4096];
  logic [ADDR_W-1:0] acc_pc_q[$];
  logic [127:0]      acc_inst_q[$];
  logic [ADDR_W-1:0] exp_q[$];
  int                rd_cnt = 0;

  inst_fetch dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_pc   (start_pc),
    .o_imem_rd_en (imem_rd_en),
    .o_imem_addr  (imem_addr),
    .i_imem_rdata (imem_rdata),
    .o_inst       (inst),
    .o_inst_valid (inst_valid),
    .i_inst_ready (inst_ready),
    .i_err_inst   (err_inst),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_pc         (pc),
    .o_state      (state)
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    .o_inst_cnt   (inst_cnt),
    .o_stall_cnt  (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction RAM model, one cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  // monitor: accepted instructions and read strobes
  always begin
    @(negedge clk);
    #2;
    if (inst_valid && inst_ready && !err_inst) begin
      acc_pc_q.push_back(pc);
      acc_inst_q.push_back(inst);
    end
    if (imem_rd_en) rd_cnt++;
  end

  function automatic logic [127:0] mk(input logic [4:0] op, input logic [11:0] tgt,
                                      input logic [15:0] tag);
    return {op, tgt, 95'd0, tag};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = '0;
  endtask

  // driver: one-cycle start pulse; returns at the following negedge
  task automatic start_run(input logic [ADDR_W-1:0] spc);
    acc_pc_q.delete();
    acc_inst_q.delete();
    @(negedge clk);
    start = 1'b1;
    start_pc = spc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // waits for o_done from a sample point, bounded
  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      #3;
      n++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL done_timeout: o_done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    n_checks++;
    if ({imem_rd_en, imem_addr, inst, inst_valid, busy, done, err, pc, state} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: rd_en=%b addr=%h valid=%b busy=%b done=%b err=%b pc=%h st=%0d, required all 0",
               imem_rd_en, imem_addr, inst_valid, busy, done, err, pc, state);
    end
    @(negedge clk);
    #3;
    n_checks++;
    if (state !== 2'd0 || imem_rd_en !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle_hold: st=%0d rd_en=%b, required 0 0", state, imem_rd_en);
    end
  endtask

  task automatic test_linear();
    int lat;
    clear_mem();
    mem[12'h010] = mk(OP_DMA, 12'h0, 16'h0010);
    mem[12'h011] = mk(OP_DMA, 12'h0, 16'h0011);
    mem[12'h012] = mk(OP_DMA, 12'h0, 16'h0012);
    mem[12'h013] = mk(OP_STOP, 12'h0, 16'h0013);
    inst_ready = 1'b1;
    start_run(12'h010);
    #3;
    lat = 0;
    while (!inst_valid && lat < 20) begin
      @(negedge clk);
      #3;
      lat++;
    end
    n_checks++;
    if (lat !== 2) begin
      n_errors++;
      $display("FAIL linear_first_latency: %0d cycles, required 2", lat);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (inst_valid !== 1'b1 || pc !== ADDR_W'(12'h010 + k) || inst !== mem[12'h010 + k]) begin
        n_errors++;
        $display("FAIL linear_seq%0d: valid=%b pc=%h inst=%h, required 1 %h %h",
                 k, inst_valid, pc, inst, 12'h010 + k, mem[12'h010 + k]);
      end
      @(negedge clk);
      #3;
    end
    n_checks++;
    if (done !== 1'b1 || state !== 2'd2 || busy !== 1'b0 || inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL linear_done_pulse: done=%b st=%0d busy=%b valid=%b, required 1 2 0 0",
               done, state, busy, inst_valid);
    end
    @(negedge clk);
    #3;
    n_checks++;
    if (done !== 1'b0 || state !== 2'd0) begin
      n_errors++;
      $display("FAIL linear_back_idle: done=%b st=%0d, required 0 0", done, state);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int snap;
    clear_mem();
    for (int i = 0; i < 8; i++) mem[12'h040 + i] = mk(OP_DMA, 12'h0, 16'(16'h0040 + i));
    mem[12'h048] = mk(OP_STOP, 12'h0, 16'h0048);
    inst_ready = 1'b1;
    start_run(12'h040);
    #3;
    lat = 0;
    while (!inst_valid && lat < 20) begin
      @(negedge clk);
      #3;
      lat++;
    end
    // 0x40 and 0x41 accepted, then the decoder stalls on 0x42
    @(negedge clk);
    @(negedge clk);
    inst_ready = 1'b0;
    snap = rd_cnt;
    for (int k = 0; k < 5; k++) begin
      #3;
      n_checks++;
      if (inst_valid !== 1'b1 || pc !== 12'h042 || inst !== mem[12'h042]) begin
        n_errors++;
        $display("FAIL bp_hold%0d: valid=%b pc=%h, required 1 042", k, inst_valid, pc);
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (rd_cnt - snap !== 0) begin
      n_errors++;
      $display("FAIL bp_no_reads: %0d reads during stall, required 0", rd_cnt - snap);
    end
    inst_ready = 1'b1;
    #2;
    wait_done(40);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(ADDR_W'(12'h040 + i));
    n_checks++;
    if (acc_pc_q.size() !== exp_q.size()) begin
      n_errors++;
      $display("FAIL bp_count: %0d accepted, required %0d", acc_pc_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < acc_pc_q.size(); i++) begin
      n_checks++;
      if (acc_pc_q[i] !== exp_q[i] || acc_inst_q[i] !== mem[exp_q[i]]) begin
        n_errors++;
        $display("FAIL bp_order%0d: pc=%h, required %h", i, acc_pc_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_jump();
    int lat;
    clear_mem();
    mem[12'h020] = mk(OP_JUMP, 12'h100, 16'h0020);
    mem[12'h021] = mk(OP_DMA, 12'h0, 16'h0021);
    mem[12'h100] = mk(OP_STOP, 12'h0, 16'h0100);
    inst_ready = 1'b1;
    start_run(12'h020);
    #3;
    lat = 0;
    while (!inst_valid && lat < 30) begin
      @(negedge clk);
      #3;
      lat++;
    end
    n_checks++;
    if (lat !== 5 || pc !== 12'h100) begin
      n_errors++;
      $display("FAIL jump_first: latency=%0d pc=%h, required 5 100", lat, pc);
    end
    wait_done(20);
    n_checks++;
    if (acc_pc_q.size() !== 1) begin
      n_errors++;
      $display("FAIL jump_count: %0d accepted, required 1", acc_pc_q.size());
    end else if (acc_pc_q[0] !== 12'h100 || acc_inst_q[0] !== mem[12'h100]) begin
      n_errors++;
      $display("FAIL jump_target: pc=%h, required 100", acc_pc_q[0]);
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[12'hFFF] = mk(OP_IOB2N, 12'h0, 16'h0FFF);
    mem[12'h000] = mk(OP_STOP, 12'h0, 16'h0000);
    inst_ready = 1'b1;
    start_run(12'hFFF);
    #3;
    wait_done(20);
    exp_q.delete();
    exp_q.push_back(12'hFFF);
    exp_q.push_back(12'h000);
    n_checks++;
    if (acc_pc_q.size() !== 2) begin
      n_errors++;
      $display("FAIL wrap_count: %0d accepted, required 2", acc_pc_q.size());
    end
    for (int i = 0; i < 2 && i < acc_pc_q.size(); i++) begin
      n_checks++;
      if (acc_pc_q[i] !== exp_q[i] || acc_inst_q[i] !== mem[exp_q[i]]) begin
        n_errors++;
        $display("FAIL wrap_seq%0d: pc=%h, required %h", i, acc_pc_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_error();
    bit hit;
    int snap;
    clear_mem();
    for (int i = 3; i < 9; i++) mem[i] = mk(OP_DMA, 12'h0, 16'(i));
    mem[9] = mk(OP_STOP, 12'h0, 16'h0009);
    inst_ready = 1'b1;
    start_run(12'h003);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      #1;
      if (inst_valid && pc == 12'h005) begin
        err_inst = 1'b1;
        hit = 1'b1;
      end
      @(negedge clk);
    end
    err_inst = 1'b0;
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL err_head_reach: head never at 005, required reached");
    end
    #3;
    n_checks++;
    if (err !== 1'b1 || inst_valid !== 1'b0 || state !== 2'd3 || imem_rd_en !== 1'b0) begin
      n_errors++;
      $display("FAIL err_enter: err=%b valid=%b st=%0d rd_en=%b, required 1 0 3 0",
               err, inst_valid, state, imem_rd_en);
    end
    snap = rd_cnt;
    repeat (4) @(negedge clk);
    #3;
    n_checks++;
    if (rd_cnt - snap !== 0 || err !== 1'b1 || inst_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL err_halted: reads=%0d err=%b valid=%b, required 0 1 0", rd_cnt - snap, err, inst_valid);
    end
    n_checks++;
    if (acc_pc_q.size() !== 2 || acc_pc_q[0] !== 12'h003 || acc_pc_q[1] !== 12'h004) begin
      n_errors++;
      $display("FAIL err_accepted: %0d accepted, required 003 004 only", acc_pc_q.size());
    end
    start_run(12'h003);
    #3;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL err_restart: err=%b busy=%b, required 0 1", err, busy);
    end
    wait_done(30);
    n_checks++;
    if (acc_pc_q.size() !== 7) begin
      n_errors++;
      $display("FAIL err_rerun_count: %0d accepted, required 7", acc_pc_q.size());
    end
    for (int i = 0; i < 7 && i < acc_pc_q.size(); i++) begin
      n_checks++;
      if (acc_pc_q[i] !== ADDR_W'(3 + i)) begin
        n_errors++;
        $display("FAIL err_rerun_seq%0d: pc=%h, required %h", i, acc_pc_q[i], 3 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    for (int i = 0; i < 8; i++) mem[12'h040 + i] = mk(OP_DMA, 12'h0, 16'(16'h0040 + i));
    inst_ready = 1'b1;
    start_run(12'h040);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      n_checks++;
      if ({imem_rd_en, imem_addr, inst, inst_valid, busy, done, err, pc, state} !== '0) begin
        n_errors++;
        $display("FAIL rst_mid%0d: rd_en=%b valid=%b busy=%b pc=%h st=%0d, required all 0",
                 k, imem_rd_en, inst_valid, busy, pc, state);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_pc = '0;
    inst_ready = 1'b0;
    err_inst = 1'b0;
    clear_mem();
    test_reset();
    test_linear();
    test_backpressure();
    test_jump();
    test_wrap();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
